program_counter: RTL and testbench

- 15-bit program counter for the Hack CPU; holds the address of the next instruction to fetch from instruction ROM.
- Each cycle it does one of three things: clears to zero (reset), loads a jump target (load), or advances by one (default).
- Sits between the CPU jump-decision logic (drives in/load) and the ROM address bus (consumes out).

---
 rtl/program_counter.sv | 33 +++
 tb/tb_program_counter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// 15-bit Hack CPU program counter: synchronous active-low clear, load of a jump
// target, otherwise increment by one with natural wrap-around.
module program_counter #(
    parameter int unsigned           WIDTH       = 15,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;

    // Reset beats load, load beats increment; the add wraps modulo 2^WIDTH.
    always_comb begin
        w_next = r_cnt + WIDTH'(1);
        if (!reset) begin
            w_next = RESET_VALUE;
        end else if (load) begin
            w_next = in;
        end
    end

    always_ff @(posedge clk) begin
        r_cnt <= w_next;
    end

    assign out = r_cnt;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a driver pushes model predictions into a
// queue at each negedge; a monitor pops and compares just after each rising edge.
module tb_program_counter;

    localparam int unsigned WIDTH = 15;
    localparam int unsigned MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic [WIDTH-1:0] out;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned model  = 0;

    program_counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(15'h0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .load (load),
        .out  (out)
    );

    always #5 clk = ~clk;

    // Reference: the next PC value follows directly from the priority rules.
    task automatic drive(input bit rst_n, input bit ld, input int unsigned val, input string tag);
        sb_item_t it;
        @(negedge clk);
        reset = rst_n;
        load  = ld;
        in    = val[WIDTH-1:0];
        if (!rst_n)   model = 0;
        else if (ld)  model = val % MODV;
        else          model = (model + 1) % MODV;
        it.tag = tag;
        it.exp = model[WIDTH-1:0];
        sb_q.push_back(it);
    endtask

    // Monitor: out is valid right after every edge for which a prediction exists.
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                n_cmp++;
                if (out !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: out=0x%04h expected=0x%04h at %0t", it.tag, out, it.exp, $time);
                end
            end
        end
    end

    initial begin
        int unsigned r;
        int unsigned wait_cnt;

        // Reset, then count from zero
        drive(1'b0, 1'b0, 32'h1234, "reset");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, "count_after_reset");
        // Load and continue counting
        drive(1'b1, 1'b1, 32'h1234, "load");
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 0, "count_after_load");
        // Priority
        drive(1'b0, 1'b1, 32'h5555, "reset_beats_load");
        drive(1'b1, 1'b1, 32'h5555, "load_after_reset");
        drive(1'b1, 1'b0, 0, "inc_after_load");
        // Wrap-around
        drive(1'b1, 1'b1, 32'h7FFE, "load_7ffe");
        drive(1'b1, 1'b0, 0, "inc_to_7fff");
        drive(1'b1, 1'b0, 0, "wrap_to_0");
        // Reset mid-count
        drive(1'b1, 1'b1, 32'h0100, "load_0100");
        drive(1'b1, 1'b0, 0, "inc_0101");
        drive(1'b1, 1'b0, 0, "inc_0102");
        drive(1'b0, 1'b0, 0, "reset_mid_count");
        drive(1'b1, 1'b0, 0, "resume_from_0");
        // Held reset
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h7FFF, "reset_held");
        // Back-to-back loads
        drive(1'b1, 1'b1, 32'h0010, "b2b_load_0010");
        drive(1'b1, 1'b1, 32'h7FFF, "b2b_load_7fff");
        drive(1'b1, 1'b1, 32'h0000, "b2b_load_0000");
        // load with in == cnt+1 behaves like increment
        drive(1'b1, 1'b1, 32'h0001, "load_eq_inc");

        // Randomized traffic, biased toward the wrap boundary
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       drive(1'b0, 1'($urandom_range(0, 1)), $urandom, "rand_reset");
            else if (r < 15) drive(1'b1, 1'b1, MODV - $urandom_range(1, 3), "rand_load_near_wrap");
            else if (r < 40) drive(1'b1, 1'b1, $urandom, "rand_load");
            else             drive(1'b1, 1'b0, $urandom, "rand_inc");
        end

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
